// File: rtl/priority_encoder_8to3_if.sv
// priority_encoder_8to3_if: request/grant bundle; master drives req/mask/ack, slave returns code/valid/pending
interface priority_encoder_8to3_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  modport master (output req, mask, ack, input code, valid, pending);
  modport slave (input req, mask, ack, output code, valid, pending);
endinterface

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: latches 8 request lines and issues one 3-bit grant code at a time, held until ack
// Ports: clk; rst (sync, active-high); bus (slave): req/mask/ack in, code/valid/pending out
// Macro PRIORITY_ENCODER_8TO3_ROUND_ROBIN_EN: round-robin search from a rotating pointer instead of fixed lowest-index priority
module priority_encoder_8to3 (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_8to3_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_pending, w_elig, w_clr;
  logic [2:0] r_code, w_sel, w_base;
  logic       w_hit, w_grant, w_done;
`ifdef PRIORITY_ENCODER_8TO3_ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_done) r_ptr <= r_code + 3'd1;
  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif
  assign w_elig = r_pending & ~bus.mask;
  assign w_hit  = |w_elig;
  // descending scan so the eligible line closest to w_base (wrapping) is written last and wins
  always_comb begin
    w_sel = '0;
    for (int k = 7; k >= 0; k--)
      if (w_elig[w_base + 3'(k)]) w_sel = w_base + 3'(k);
  end
  always_comb begin
    w_grant = (r_state == IDLE) && w_hit;
    w_done  = (r_state == ISSUE) && bus.ack;
    w_next  = w_grant ? ISSUE : w_done ? IDLE : r_state;
  end
  // clear before OR-ing in req so a request on the ack edge keeps its bit pending
  assign w_clr = w_done ? 8'd1 << r_code : 8'd0;
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_code    <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_pending & ~w_clr) | bus.req;
      if (w_grant) r_code <= w_sel;
    end
  assign bus.code    = r_code;
  assign bus.valid   = (r_state == ISSUE);
  assign bus.pending = r_pending;
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// tb_priority_encoder_8to3: directed scenarios plus randomized run against a behavioural arbiter model
module tb_priority_encoder_8to3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  priority_encoder_8to3_if bus ();
  priority_encoder_8to3 dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0] m_pend;
  logic       m_busy;
  logic [2:0] m_code;
  int         m_ptr;
  function automatic void model_edge();
    logic [7:0] p;
    if (rst) begin
      m_pend = '0; m_busy = 1'b0; m_code = '0; m_ptr = 0;
      return;
    end
    p = m_pend;
    if (m_busy && bus.ack) begin
      p[m_code] = 1'b0;
      m_busy = 1'b0;
`ifdef PRIORITY_ENCODER_8TO3_ROUND_ROBIN_EN
      m_ptr = (int'(m_code) + 1) % 8;
`endif
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_ptr + k) % 8;
        if (m_pend[i] && !bus.mask[i]) begin
          m_busy = 1'b1;
          m_code = 3'(i);
          break;
        end
      end
    end
    m_pend = p | bus.req;
  endfunction
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    bus.req = 8'hFF; bus.ack = 1'b1;
    do_reset();
    bus.req = 8'h00; bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", bus.pending); end
    checks++; if (bus.code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", bus.code); end
  endtask
  task automatic test_single();
    do_reset();
    bus.req = 8'h20;
    tick();
    bus.req = 8'h00;
    checks++; if (bus.pending !== 8'h20 || bus.valid !== 1'b0) begin errors++; $display("FAIL single_capture got pend=%h valid=%0b want 20/0", bus.pending, bus.valid); end
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd5) begin errors++; $display("FAIL single_grant got valid=%0b code=%0d want 1/5", bus.valid, bus.code); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin errors++; $display("FAIL single_ack got pend=%h valid=%0b want 00/0", bus.pending, bus.valid); end
  endtask
  task automatic test_multi();
    logic [2:0] exp [3] = '{3'd0, 3'd4, 3'd7};
    do_reset();
    bus.req = 8'h91;
    tick();
    bus.req = 8'h00;
    for (int g = 0; g < 3; g++) begin
      int n = 0;
      while (!bus.valid && n < 10) begin tick(); n++; end
      checks++; if (bus.valid !== 1'b1 || bus.code !== exp[g]) begin errors++; $display("FAIL multi_grant%0d got valid=%0b code=%0d want 1/%0d", g, bus.valid, bus.code, exp[g]); end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL multi_gap%0d got valid=%0b want 0", g, bus.valid); end
    end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL multi_drain got %h want 00", bus.pending); end
  endtask
  task automatic test_back_to_back();
    logic [2:0] want;
    do_reset();
    bus.req = 8'h03;
    for (int g = 0; g < 6; g++) begin
      int n = 0;
      while (!bus.valid && n < 10) begin tick(); n++; end
`ifdef PRIORITY_ENCODER_8TO3_ROUND_ROBIN_EN
      want = 3'(g % 2);
`else
      want = 3'd0;
`endif
      checks++; if (bus.valid !== 1'b1 || bus.code !== want) begin errors++; $display("FAIL b2b_grant%0d got valid=%0b code=%0d want 1/%0d", g, bus.valid, bus.code, want); end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h03) begin errors++; $display("FAIL b2b_gap%0d got valid=%0b pend=%h want 0/03", g, bus.valid, bus.pending); end
    end
    bus.req = 8'h00;
  endtask
  task automatic test_mask();
    do_reset();
    bus.mask = 8'h04; bus.req = 8'h0C;
    tick();
    bus.req = 8'h00;
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd3) begin errors++; $display("FAIL mask_grant got valid=%0b code=%0d want 1/3", bus.valid, bus.code); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h04) begin errors++; $display("FAIL mask_blocked got valid=%0b pend=%h want 0/04", bus.valid, bus.pending); end
    bus.mask = 8'h00;
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd2) begin errors++; $display("FAIL mask_release got valid=%0b code=%0d want 1/2", bus.valid, bus.code); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask
  task automatic test_hold();
    do_reset();
    bus.req = 8'h40;
    tick();
    bus.req = 8'h00;
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd6) begin errors++; $display("FAIL hold_grant got valid=%0b code=%0d want 1/6", bus.valid, bus.code); end
    bus.mask = 8'hFF; bus.req = 8'h02;
    tick();
    bus.req = 8'h00;
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd6) begin errors++; $display("FAIL hold_1 got valid=%0b code=%0d want 1/6", bus.valid, bus.code); end
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd6 || bus.pending !== 8'h42) begin errors++; $display("FAIL hold_2 got valid=%0b code=%0d pend=%h want 1/6/42", bus.valid, bus.code, bus.pending); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h02) begin errors++; $display("FAIL hold_ack got valid=%0b pend=%h want 0/02", bus.valid, bus.pending); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h02 || bus.code !== 3'd6) begin errors++; $display("FAIL stray_ack got valid=%0b pend=%h code=%0d want 0/02/6", bus.valid, bus.pending, bus.code); end
    bus.mask = 8'h00;
  endtask
  task automatic test_simultaneous();
    do_reset();
    bus.req = 8'h08;
    tick();
    bus.req = 8'h00;
    tick();
    bus.ack = 1'b1; bus.req = 8'h08;
    tick();
    bus.ack = 1'b0; bus.req = 8'h00;
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h08) begin errors++; $display("FAIL ack_set got valid=%0b pend=%h want 0/08", bus.valid, bus.pending); end
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd3) begin errors++; $display("FAIL regrant got valid=%0b code=%0d want 1/3", bus.valid, bus.code); end
    rst = 1'b1; bus.req = 8'hFF; bus.ack = 1'b1;
    tick();
    rst = 1'b0; bus.req = 8'h00; bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL rst_issue got valid=%0b pend=%h want 0/00", bus.valid, bus.pending); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      bus.mask = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
      bus.ack  = 1'($urandom);
      rst      = ($urandom_range(96) == 0);
      tick();
      checks++;
      if ({bus.code, bus.valid, bus.pending} !== {m_code, m_busy, m_pend}) begin
        errors++;
        $display("FAIL random_c%0d got code=%0d valid=%0b pend=%h want %0d/%0b/%h", c, bus.code, bus.valid, bus.pending, m_code, m_busy, m_pend);
      end
    end
    rst = 1'b0; bus.req = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0;
  endtask
  initial begin
    rst = 1'b0; bus.req = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_mask();
    test_hold();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
